alu_seq_ctrl: RTL and testbench

Command sequencer that wraps the 4-bit ALU datapath behind a nibble-serial ready/valid interface. It collects a 3-nibble command (opcode, A, B), runs the operation (single-cycle ops or a WIDTH-cycle shift-add multiply), then returns a 2-nibble response. It sits between the top-level `ui_in`/`uo_out` pin logic and the ALU core and owns all sequencing, backpressure and `ena` gating.

---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/alu4_core.sv | 63 ++++++
 rtl/alu_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and flag layout for the nibble-serial ALU sequencer.
package alu_seq_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned FLAG_W = 4;

   localparam logic [OP_W-1:0] OP_ADD = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB = 4'd1;
   localparam logic [OP_W-1:0] OP_AND = 4'd2;
   localparam logic [OP_W-1:0] OP_OR  = 4'd3;
   localparam logic [OP_W-1:0] OP_XOR = 4'd4;
   localparam logic [OP_W-1:0] OP_SHL = 4'd5;
   localparam logic [OP_W-1:0] OP_SHR = 4'd6;
   localparam logic [OP_W-1:0] OP_MUL = 4'd7;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_C = 0;

   // Second response nibble returned for opcodes 8..15
   localparam logic [FLAG_W-1:0] ILL_RSP = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_A,
      ST_GET_B,
      ST_EXEC,
      ST_OUT0,
      ST_OUT1
   } state_t;

endpackage

// File: rtl/alu4_core.sv
// Combinational ALU for the single-cycle opcodes (ADD..SHR): result plus {Z,N,V,C}.
module alu4_core
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [OP_W-1:0]   op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic [WIDTH-1:0]  result,
   output logic [FLAG_W-1:0] flags
);

   logic [WIDTH:0] add_ext;
   logic [WIDTH:0] sub_ext;
   logic [WIDTH:0] shl_ext;
   logic [WIDTH:0] shr_ext;
   logic [1:0]     sh;
   logic           v;
   logic           c;

   always_comb begin
      sh      = b[1:0];
      add_ext = {1'b0, a} + {1'b0, b};
      sub_ext = {1'b0, a} - {1'b0, b};
      // Extra bit on the exit side captures the last bit shifted out
      shl_ext = {1'b0, a} << sh;
      shr_ext = {a, 1'b0} >> sh;
      result  = '0;
      v       = 1'b0;
      c       = 1'b0;
      case (op)
         OP_ADD: begin
            result = add_ext[WIDTH-1:0];
            c      = add_ext[WIDTH];
            v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result = sub_ext[WIDTH-1:0];
            c      = sub_ext[WIDTH];
            v      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_SHL: begin
            result = shl_ext[WIDTH-1:0];
            c      = shl_ext[WIDTH];
         end
         OP_SHR: begin
            result = shr_ext[WIDTH:1];
            c      = shr_ext[0];
         end
         default: ;
      endcase
      flags         = '0;
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[WIDTH-1];
      flags[FLAG_V] = v;
      flags[FLAG_C] = c;
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Nibble-serial command sequencer: collects op/A/B, executes (incl. shift-add MUL),
// and returns a two-nibble response under ready/valid handshakes gated by ena.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ena,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned PROD_W = 2 * WIDTH;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [OP_W-1:0]     op;
   logic [WIDTH-1:0]    a;
   logic [WIDTH-1:0]    b;
   logic [WIDTH-1:0]    hi;
   logic [PROD_W-1:0]   prod;
   logic [PROD_W-1:0]   prod_nxt;
   logic [WIDTH-1:0]    core_res;
   logic [FLAG_W-1:0]   core_flags;
   logic                in_acc;
   logic                out_acc;
   logic                is_mul;
   logic                is_ill;
   logic                mul_last;
   logic                exec_done;

   alu4_core #(.WIDTH(WIDTH)) u_core (
      .op     (op),
      .a      (a),
      .b      (b),
      .result (core_res),
      .flags  (core_flags)
   );

   // Handshake and status decodes from registered state
   always_comb begin
      in_ready  = ena & ((state == ST_IDLE) | (state == ST_GET_A) | (state == ST_GET_B));
      out_valid = ena & ((state == ST_OUT0) | (state == ST_OUT1));
      busy      = (state == ST_EXEC) | (state == ST_OUT0) | (state == ST_OUT1);
      in_acc    = ena & in_valid & in_ready;
      out_acc   = ena & out_valid & out_ready;
      is_mul    = (op == OP_MUL);
      is_ill    = (op > OP_MUL);
      mul_last  = (cnt == CNT_W'(WIDTH - 1));
      exec_done = ena & (state == ST_EXEC) & (~is_mul | mul_last);
      prod_nxt  = prod + (b[cnt] ? (PROD_W'(a) << cnt) : '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (in_acc)    state_nxt = ST_GET_A;
         ST_GET_A: if (in_acc)    state_nxt = ST_GET_B;
         ST_GET_B: if (in_acc)    state_nxt = ST_EXEC;
         ST_EXEC:  if (exec_done) state_nxt = ST_OUT0;
         ST_OUT0:  if (out_acc)   state_nxt = ST_OUT1;
         ST_OUT1:  if (out_acc)   state_nxt = ST_IDLE;
         default:                 state_nxt = ST_IDLE;
      endcase
   end

   // Command capture, execution and response registers; all frozen while ena is low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op       <= '0;
         a        <= '0;
         b        <= '0;
         hi       <= '0;
         prod     <= '0;
         cnt      <= '0;
         out_data <= '0;
      end else if (ena) begin
         if (in_acc) begin
            if (state == ST_IDLE) op <= OP_W'(in_data);
            if (state == ST_GET_A) a <= in_data;
            if (state == ST_GET_B) begin
               b    <= in_data;
               prod <= '0;
               cnt  <= '0;
            end
         end
         if (state == ST_EXEC) begin
            if (is_ill) begin
               out_data <= '0;
               hi       <= WIDTH'(ILL_RSP);
            end else if (is_mul) begin
               prod <= prod_nxt;
               if (mul_last) begin
                  cnt      <= '0;
                  out_data <= prod_nxt[WIDTH-1:0];
                  hi       <= prod_nxt[PROD_W-1:WIDTH];
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end else begin
               out_data <= core_res;
               hi       <= WIDTH'(core_flags);
            end
         end
         if (out_acc && (state == ST_OUT0)) out_data <= hi;
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: directed cases plus randomized commands
// against an integer-arithmetic reference model.
module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;

   logic       bp_mode;
   logic       ready_force;
   logic       rnd_bit;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         t_b = 0;
   int         lat_exp = 0;
   int         lat_req = 0;
   int         lat_seen = 0;
   logic [3:0] q[$];

   logic       held = 1'b0;
   logic [3:0] held_val = 4'h0;

   alu_seq_ctrl #(.WIDTH(4)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .ena       (ena),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end
   assign out_ready = bp_mode ? rnd_bit : ready_force;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
   endtask

   // Reference: plain integer arithmetic over 4-bit values; returns {first, second} nibble
   function automatic logic [7:0] model(input int op, input int a, input int b);
      int r, c, v, sa, sb, s, p;
      r = 0; c = 0; v = 0;
      sa = (a > 7) ? a - 16 : a;
      sb = (b > 7) ? b - 16 : b;
      case (op)
         0: begin r = (a + b) % 16; c = int'((a + b) > 15); v = int'((sa + sb > 7) || (sa + sb < -8)); end
         1: begin r = (a - b + 16) % 16; c = int'(a < b); v = int'((sa - sb > 7) || (sa - sb < -8)); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin s = b % 4; r = (a << s) % 16; c = (s > 0) ? ((a << s) >> 4) & 1 : 0; end
         6: begin s = b % 4; r = a >> s; c = (s > 0) ? (a >> (s - 1)) & 1 : 0; end
         7: begin p = a * b; return {4'(p % 16), 4'(p / 16)}; end
         default: return 8'h0F;
      endcase
      return {4'(r), (r == 0), (r > 7), v[0], c[0]};
   endfunction

   // Called just after a rising edge; returns just after the edge that accepts the nibble
   task automatic send_nib(input int d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = 4'(d);
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) note_fail("in_accept_wait");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 4'($urandom);
   endtask

   task automatic send_cmd(input int op, input int a, input int b, input int lat);
      logic [7:0] e;
      e = model(op, a, b);
      q.push_back(e[7:4]);
      q.push_back(e[3:0]);
      send_nib(op);
      send_nib(a);
      send_nib(b);
      t_b     = cyc;
      lat_exp = lat;
      if (lat > 0) lat_req++;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((q.size() != 0 || busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0 || busy) note_fail("drain_wait");
      @(posedge clk);
      #1;
   endtask

   // Monitor: latency of first valid, stability under backpressure, scoreboard pop on accept
   always @(negedge clk) begin
      if (lat_req != lat_seen && out_valid) begin
         chk("first_valid_latency", cyc - t_b, lat_exp);
         lat_seen = lat_req;
      end
      if (held && out_valid) chk("out_data_stable", int'(out_data), int'(held_val));
      held = 1'b0;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected actual=%0h required=none", out_data);
         end else begin
            chk("rsp_nibble", int'(out_data), int'(q.pop_front()));
         end
      end else if (out_valid) begin
         held     = 1'b1;
         held_val = out_data;
      end
   end

   initial begin
      int op, a, b, n;
      rst_n       = 1'b0;
      ena         = 1'b1;
      in_valid    = 1'b0;
      in_data     = 4'h0;
      bp_mode     = 1'b0;
      ready_force = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // ADD with carry and overflow, SUB with borrow
      send_cmd(0, 9, 8, 1);
      wait_idle();
      send_cmd(1, 3, 5, 1);
      wait_idle();

      // MUL: four EXEC cycles with busy high and no response yet
      send_cmd(7, 15, 15, 4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mul_busy", int'(busy), 1);
         chk("mul_no_valid", int'(out_valid), 0);
      end
      @(posedge clk);
      #1;
      wait_idle();

      // Illegal opcode under backpressure
      ready_force = 1'b0;
      send_cmd(10, 3, 3, 1);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) note_fail("ill_valid_wait");
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_data", int'(out_data), 0);
         chk("bp_hold_valid", int'(out_valid), 1);
         @(negedge clk);
      end
      @(posedge clk);
      #1 ready_force = 1'b1;
      repeat (3) @(negedge clk);
      chk("ready_after_out1", int'(in_ready), 1);
      chk("idle_after_out1", int'(busy), 0);
      @(posedge clk);
      #1;

      // ena low for two cycles in the middle of a MUL
      send_cmd(7, 15, 15, 6);
      @(posedge clk);
      #1 ena = 1'b0;
      @(negedge clk);
      chk("gated_in_ready", int'(in_ready), 0);
      chk("gated_out_valid", int'(out_valid), 0);
      @(posedge clk);
      @(posedge clk);
      #1 ena = 1'b1;
      wait_idle();

      // Reset while waiting for B discards the partial command
      send_nib(1);
      send_nib(5);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_out_data", int'(out_data), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send_cmd(2, 12, 10, 1);
      wait_idle();

      // Randomized commands with random backpressure and input gaps
      bp_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
         a  = int'($urandom_range(0, 15));
         b  = int'($urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         send_cmd(op, a, b, (op == 7) ? 4 : 1);
      end
      wait_idle();
      bp_mode = 1'b0;

      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
